// File: rtl/dna_id_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// dna_id_reader : reads a DNA_PORT-style serial ID into a parallel word, with
//                 start/busy/done handshake, rate divider and expected-ID compare
// Revision      : 1.0
// ============================================================================

module dna_id_reader #(
    parameter int                  ID_WIDTH    = 57,
    parameter int                  OUT_WIDTH   = 64,
    parameter int                  DIV         = 1,
    parameter int                  AUTO_START  = 1,
    parameter int                  RECIRC      = 1,
    parameter logic [ID_WIDTH-1:0] EXPECTED_ID = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    output logic                 dna_read_o,
    output logic                 dna_shift_o,
    output logic                 dna_din_o,
    input  logic                 dna_dout_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 id_valid_o,
    output logic [OUT_WIDTH-1:0] id_o,
    output logic                 match_o
);

    localparam int                CNT_W    = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
    localparam logic [7:0]        DIV_M1   = 8'(DIV - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(ID_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            div_q, div_d;
    logic [CNT_W-1:0]      bit_q, bit_d;
    logic [ID_WIDTH-1:0]   sreg_q, sreg_d;
    logic [OUT_WIDTH-1:0]  id_q, id_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  match_q, match_d;
    logic                  read_q, read_d;
    logic                  shift_q, shift_d;
    logic                  first_q;

    logic                  w_tick;
    logic                  w_bit;
    logic                  w_go;
    logic [ID_WIDTH-1:0]   w_sreg_shift;

    always_comb begin
        w_tick = (div_q == 8'd0);
        // Anything other than a clean 1 on DOUT (X/Z included) is taken as 0.
        w_bit = 1'b0;
        if (dna_dout_i) begin
            w_bit = 1'b1;
        end
        w_sreg_shift = (sreg_q << 1) | ID_WIDTH'(w_bit);

        state_d = state_q;
        div_d   = w_tick ? DIV_M1 : (div_q - 8'd1);
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        id_d    = id_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        match_d = match_q;
        w_go    = 1'b0;

        case (state_q)
            ST_IDLE:  w_go = start_i || first_q;
            ST_DONE:  w_go = start_i;
            ST_LOAD: begin
                if (w_tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    sreg_d = w_sreg_shift;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_DONE;
                        id_d    = OUT_WIDTH'(w_sreg_shift);
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        match_d = (w_sreg_shift == EXPECTED_ID);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_go) begin
            state_d = ST_LOAD;
            div_d   = DIV_M1;
            busy_d  = 1'b1;
            valid_d = 1'b0;
            match_d = 1'b0;
            sreg_d  = '0;
            bit_d   = '0;
        end

        // Strobes are registered, so they look one cycle ahead at the next tick.
        read_d  = (state_d == ST_LOAD)  && (div_d == 8'd0);
        shift_d = (state_d == ST_SHIFT) && (div_d == 8'd0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            div_q   <= 8'd0;
            bit_q   <= '0;
            sreg_q  <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
            read_q  <= 1'b0;
            shift_q <= 1'b0;
            first_q <= (AUTO_START != 0);
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            match_q <= match_d;
            read_q  <= read_d;
            shift_q <= shift_d;
            first_q <= 1'b0;
        end
    end

    // DIN must see DOUT in the same cycle for the primitive to rotate back to its original value.
    generate
        if (RECIRC != 0) begin : g_recirc
            assign dna_din_o = w_bit;
        end else begin : g_no_recirc
            assign dna_din_o = 1'b0;
        end
    endgenerate

    assign dna_read_o  = read_q;
    assign dna_shift_o = shift_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign id_valid_o  = valid_q;
    assign id_o        = id_q;
    assign match_o     = match_q;

endmodule

`default_nettype wire

// File: tb/tb_dna_id_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_dna_id_reader : directed bench with DNA_PORT models and a timeline model
// Revision         : 1.0
// ============================================================================

module tb_dna_id_reader;

    localparam int             W     = 57;
    localparam logic [W-1:0]   DNA   = 57'habcdef12;
    localparam logic [W-1:0]   EXP_A = 57'habcdef12;
    localparam logic [W-1:0]   EXP_B = 57'habcdef13;
    localparam int             DIV_A = 1;
    localparam int             DIV_B = 4;
    localparam int             TA    = DIV_A * (W + 1);
    localparam int             TB    = DIV_B * (W + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    always #5 clk = ~clk;

    logic        a_read, a_shift, a_din, a_dout, a_busy, a_done, a_valid, a_match;
    logic [63:0] a_id;
    logic        b_read, b_shift, b_din, b_dout, b_busy, b_done, b_valid, b_match;
    logic [63:0] b_id;

    dna_id_reader #(.ID_WIDTH(W), .OUT_WIDTH(64), .DIV(DIV_A), .AUTO_START(1),
                    .RECIRC(1), .EXPECTED_ID(EXP_A)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a),
        .dna_read_o(a_read), .dna_shift_o(a_shift), .dna_din_o(a_din),
        .dna_dout_i(a_dout), .busy_o(a_busy), .done_o(a_done),
        .id_valid_o(a_valid), .id_o(a_id), .match_o(a_match));

    dna_id_reader #(.ID_WIDTH(W), .OUT_WIDTH(64), .DIV(DIV_B), .AUTO_START(0),
                    .RECIRC(1), .EXPECTED_ID(EXP_B)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b),
        .dna_read_o(b_read), .dna_shift_o(b_shift), .dna_din_o(b_din),
        .dna_dout_i(b_dout), .busy_o(b_busy), .done_o(b_done),
        .id_valid_o(b_valid), .id_o(b_id), .match_o(b_match));

    // DNA_PORT behaviour: READ loads the fixed ID, SHIFT moves DOUT out and DIN in.
    logic [W-1:0] pa = '0;
    logic [W-1:0] pb = '0;
    int           sca = 0;
    int           xpos_a = -1;
    logic         xval = 1'bx;

    always @(posedge clk) begin
        if (a_read) begin
            pa  <= DNA;
            sca <= 0;
        end else if (a_shift) begin
            pa  <= {pa[W-2:0], a_din};
            sca <= sca + 1;
        end
        if (b_read)       pb <= DNA;
        else if (b_shift) pb <= {pb[W-2:0], b_din};
    end

    assign a_dout = (sca == xpos_a) ? xval : pa[W-1];
    assign b_dout = pb[W-1];

    int rda = 0, sha = 0, dna_cnt = 0, rdb = 0, shb = 0;
    always @(posedge clk) begin
        if (a_read)  rda     <= rda + 1;
        if (a_shift) sha     <= sha + 1;
        if (a_done)  dna_cnt <= dna_cnt + 1;
        if (b_read)  rdb     <= rdb + 1;
        if (b_shift) shb     <= shb + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Timeline model: k = cycles since the accepted start edge.
    function automatic logic [5:0] exp_out(input int k, input int div,
                                           input logic [W-1:0] shown, input logic [W-1:0] expid);
        int   t;
        logic busy, done, valid, rd, sh;
        t = div * (W + 1);
        if (k < 0) return 6'b0;
        busy  = (k < t);
        done  = (k == t);
        valid = (k >= t);
        rd    = (k == div - 1);
        sh    = (k >= 2 * div - 1) && (k <= t - 1) && ((k % div) == div - 1);
        return {busy, done, valid, rd, sh, valid && (shown == expid)};
    endfunction

    int           ka = -1, kb = -1;
    bit           firsta = 1'b1;
    logic [W-1:0] exp_id_a = DNA, pend_a = '0, shown_a = '0;
    logic [W-1:0] pend_b = '0, shown_b = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ka = -1; kb = -1; firsta = 1'b1; shown_a = '0; shown_b = '0;
        end else begin
            if ((ka < 0 && (start_a || firsta)) || (ka >= TA && start_a)) begin
                ka = 0; pend_a = exp_id_a;
            end else if (ka >= 0 && ka <= TA) begin
                ka = ka + 1;
            end
            if (ka == TA) shown_a = pend_a;
            firsta = 1'b0;
            if ((kb < 0 && start_b) || (kb >= TB && start_b)) begin
                kb = 0; pend_b = DNA;
            end else if (kb >= 0 && kb <= TB) begin
                kb = kb + 1;
            end
            if (kb == TB) shown_b = pend_b;
        end
    end

    always @(negedge clk) begin : cmp
        logic [5:0] ea, eb;
        if (!rst_n) begin
            chk("rst_ctl_a", 64'({a_busy, a_done, a_valid, a_read, a_shift, a_match}), 64'd0);
            chk("rst_id_a", a_id, 64'd0);
            chk("rst_ctl_b", 64'({b_busy, b_done, b_valid, b_read, b_shift, b_match}), 64'd0);
            chk("rst_id_b", b_id, 64'd0);
        end else begin
            ea = exp_out(ka, DIV_A, shown_a, EXP_A);
            eb = exp_out(kb, DIV_B, shown_b, EXP_B);
            chk("ctl_a", 64'({a_busy, a_done, a_valid, a_read, a_shift, a_match}), 64'(ea));
            chk("ctl_b", 64'({b_busy, b_done, b_valid, b_read, b_shift, b_match}), 64'(eb));
            if (ea[3]) chk("id_a", a_id, 64'(shown_a));
            if (eb[3]) chk("id_b", b_id, 64'(shown_b));
            if (ka < 0) chk("id_a_idle", a_id, 64'd0);
        end
    end

    task automatic wait_done_a(input string name, input int limit);
        int n;
        n = 0;
        while (!a_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < limit), 64'd1);
    endtask

    initial begin : stim
        int           n, d0, r0, s0;
        logic [W-1:0] ex;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        fork
            begin
                @(posedge clk);
                repeat (57) @(posedge clk);
                @(negedge clk);
                chk("a_valid_e57", 64'(a_valid), 64'd0);
                @(negedge clk);
                chk("a_valid_e58", 64'(a_valid), 64'd1);
                chk("a_done_e58", 64'(a_done), 64'd1);
                chk("a_match_e58", 64'(a_match), 64'd1);
                chk("a_id_lit", a_id, 64'h0000_0000_abcd_ef12);
                chk("a_read_cnt", 64'(rda), 64'd1);
                chk("a_shift_cnt", 64'(sha), 64'd57);
                chk("a_restore", 64'(pa), 64'(DNA));
                repeat (2) @(negedge clk);
                chk("a_done_cnt", 64'(dna_cnt), 64'd1);
            end
            begin
                repeat (10) @(negedge clk);
                start_b = 1'b1;
                @(negedge clk);
                start_b = 1'b0;
                repeat (231) @(negedge clk);
                chk("b_valid_231", 64'(b_valid), 64'd0);
                @(negedge clk);
                chk("b_valid_232", 64'(b_valid), 64'd1);
                chk("b_id_lit", b_id, 64'h0000_0000_abcd_ef12);
                chk("b_match_lit", 64'(b_match), 64'd0);
                chk("b_read_cnt", 64'(rdb), 64'd1);
                chk("b_shift_cnt", 64'(shb), 64'd57);
                chk("b_restore", 64'(pb), 64'(DNA));
            end
        join

        // start held through two consecutive reads
        @(negedge clk);
        d0 = dna_cnt; r0 = rda; s0 = sha;
        start_a = 1'b1;
        wait_done_a("rd2_timeout", 200);
        chk("rd2_id", a_id, 64'h0000_0000_abcd_ef12);
        @(negedge clk);
        wait_done_a("rd3_timeout", 200);
        start_a = 1'b0;
        chk("rd3_id", a_id, 64'h0000_0000_abcd_ef12);
        repeat (3) @(negedge clk);
        chk("held_done_cnt", 64'(dna_cnt - d0), 64'd2);
        chk("held_read_cnt", 64'(rda - r0), 64'd2);
        chk("held_shift_cnt", 64'(sha - s0), 64'd114);

        // reset in the middle of a read
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (sca != 30 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("shift30_timeout", 64'(n < 200), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_now_ctl_a", 64'({a_busy, a_done, a_valid, a_read, a_shift, a_match}), 64'd0);
        chk("rst_now_id_a", a_id, 64'd0);
        chk("rst_now_ctl_b", 64'({b_busy, b_done, b_valid, b_read, b_shift, b_match}), 64'd0);
        chk("rst_now_id_b", b_id, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_done_a("rerd_timeout", 200);
        chk("rerd_id", a_id, 64'h0000_0000_abcd_ef12);
        chk("rerd_match", 64'(a_match), 64'd1);

        // unknown DOUT on one bit (original bit 31)
        @(negedge clk);
        ex = DNA;
        ex[W-1-25] = (xval === 1'b1);
        exp_id_a = ex;
        xpos_a = 25;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("xrd_timeout", 200);
        chk("x_id", a_id, 64'(ex));
        chk("x_id_known", 64'($isunknown(a_id)), 64'd0);
        chk("x_match_known", 64'($isunknown(a_match)), 64'd0);
        chk("x_match", 64'(a_match), 64'(ex == EXP_A));
        chk("x_restore", 64'(pa), 64'(ex));
        xpos_a = -1;

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
